// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: shift-register FIFO. Writes shift into a delay line whose
// read tap follows the oldest entry; the popped word is parked in a
// registered valid/ready output stage. Level, almost-full and sticky
// overrun status are derived from registered state only.
module srl_fifo_ctrl #(
    parameter int WID   = 8,
    parameter int DEP   = 16,
    parameter int AFULL = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr,
    input  logic [WID-1:0]             din,
    output logic                       full,
    output logic                       ovr,
    input  logic                       ovr_clr,
    output logic [WID-1:0]             dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic [$clog2(DEP+2)-1:0]   lvl,
    output logic                       afull,
    output logic                       empty
);

    localparam int CW = $clog2(DEP + 1);
    localparam int AW = $clog2(DEP);
    localparam int LW = $clog2(DEP + 2);

    // Output handshake: the consumer takes dout on a rising edge where
    // dout_vld and dout_rdy are both high; dout holds while dout_vld is high
    // and dout_rdy is low.

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WID-1:0] dout_q, dout_d;
    logic           dout_vld_q, dout_vld_d;
    logic           ovr_q, ovr_d;
    logic [WID-1:0] line_q [DEP];
    logic [WID-1:0] line_d [DEP];

    logic [AW-1:0]  tap;
    logic           push;
    logic           pop;

    // Status and tap address, all from registered state.
    always_comb begin
        full  = (cnt_q == CW'(DEP));
        lvl   = LW'(cnt_q) + LW'(dout_vld_q);
        afull = (lvl >= LW'(AFULL));
        empty = (lvl == '0);
        tap   = (cnt_q == '0) ? '0 : AW'(cnt_q - CW'(1));
        push  = wr & ~full & ~clr;
        pop   = (cnt_q != '0) & (~dout_vld_q | dout_rdy) & ~clr;
    end

    // Next-state for counter, output stage, overrun flag and delay line.
    always_comb begin
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        ovr_d      = ovr_q;
        line_d     = line_q;

        if (clr) begin
            cnt_d      = '0;
            dout_vld_d = 1'b0;
        end else begin
            // Tap is read before the shift, so a same-cycle push cannot
            // disturb the word being popped.
            if (pop) begin
                dout_d     = line_q[tap];
                dout_vld_d = 1'b1;
            end else if (dout_vld_q && dout_rdy) begin
                dout_vld_d = 1'b0;
            end

            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        if (push) begin
            line_d[0] = din;
            for (int i = 1; i < DEP; i++) begin
                line_d[i] = line_q[i-1];
            end
        end

        // A dropped write wins over a clear request in the same cycle.
        if (wr && full && !clr) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovr_q      <= ovr_d;
        end
    end

    // Delay line storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign ovr      = ovr_q;

endmodule
